mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer for the 8-bit registered multiply-accumulate datapath. It accepts a job length, then streams operand pairs through a one-cycle registered multiplier, accumulates the products and returns a single dot-product result over a valid/ready handshake. It sits between the PS-side command/stream logic and the multiplier, and is the only block allowed to drive the multiplier operands.

Parameters:
DATA_W, 8, operand width (unsigned)
LEN_MAX, 16, maximum pairs per job
LEN_W, 5, width of len port; must satisfy 2^LEN_W > LEN_MAX
ACC_W, 20, accumulator/result width (20 covers 16 x 255 x 255 = 1 040 400 without overflow)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job request, sampled only in IDLE
len  in  LEN_W  pairs in job, latched on accepted start; values > LEN_MAX clamp to LEN_MAX
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts a pair this cycle
a  in  DATA_W  operand A
b  in  DATA_W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
acc_out  out  ACC_W  accumulated result, stable while out_valid is high
overflow  out  1  sticky per job; valid with out_valid

Behaviour:
- Reset (synchronous): state=IDLE; busy, in_ready, out_valid and overflow are 0; acc_out, accumulator, count, product register and pipe-valid are 0. Reset mid-job abandons the job and discards any pending result.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. When start=1, latch len, clear the accumulator, count and overflow. If len=0, go to DONE (result 0). Otherwise go to RUN.
- RUN: in_ready=1. A pair is accepted on in_valid and in_ready. On acceptance, prod_reg <= a*b (2*DATA_W bits, unsigned) and pipe_v <= 1; otherwise pipe_v <= 0. Each cycle with pipe_v=1 adds zero-extended prod_reg to the accumulator. count increments per accepted pair. When the accepted pair is number len, the next state is DRAIN and in_ready drops in the following cycle.
- DRAIN: one cycle; the final product is added. Then go to DONE.
- DONE: out_valid=1, acc_out=accumulator. Hold until out_ready=1, then go to IDLE; out_valid is 0 in the IDLE cycle.
- Latency: the last pair is accepted at cycle T; out_valid rises at T+2. Throughput is one pair per cycle with no bubbles while in_valid stays high.
- Gaps in in_valid during RUN are allowed. count and the accumulator hold; pipe_v is 0 for gap cycles.
- start outside IDLE is ignored. A start in the same cycle that DONE hands off is ignored; the next start must arrive in IDLE.
- out_ready while out_valid=0 has no effect.
- Overflow (default build): the accumulator wraps modulo 2^ACC_W; overflow is set if any addition carries out of bit ACC_W-1.

Optional Feature:
MAC_ACC_SAT_EN
- Defined: saturating accumulate. On carry-out the accumulator clamps to 2^ACC_W-1 and stays there for the rest of the job; overflow is set.
- Undefined: wrap-around accumulate with the sticky overflow flag, as above.
- Handshake and latency are identical in both builds.

Decomposition:
- Package mac_pkg: state enum (IDLE, RUN, DRAIN, DONE), default width constants (DATA_W, LEN_MAX, LEN_W, ACC_W), and a function for the product width.
- One sub-module, mac_mult_reg: the registered unsigned multiplier with valid passthrough (inputs a, b, v_in; outputs prod, v_out; one-cycle latency). The FSM, counter, accumulator and output register live in mac_seq_ctrl.

Test Plan:
- len=4; pairs (1,2) (3,4) (5,6) (7,8) back-to-back; out_ready=1 -> acc_out=100, overflow=0, out_valid 2 cycles after the 4th accept, busy low the cycle after.
- len=16; all pairs (255,255) -> acc_out=1 040 400, overflow=0; in_ready high for exactly 16 cycles.
- len=0 with start -> DONE next cycle, acc_out=0, no in_ready pulse.
- len=3 with in_valid toggling 1,0,1,0,1 and out_ready held 0 for 5 cycles -> acc_out stable through the hold, then IDLE after out_ready; pairs (10,10) x3 give 300.
- ACC_W=16, len=2, pairs (255,255) x2 -> default build: acc_out=64514, overflow=1; with MAC_ACC_SAT_EN: acc_out=65535, overflow=1.
- rst asserted in RUN after 2 accepts, then a new job len=1 with pair (9,9) -> first job produces no out_valid; second gives acc_out=81.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate sequencer.
package mac_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned LEN_MAX = 16;
   localparam int unsigned LEN_W   = 5;
   localparam int unsigned ACC_W   = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Full-precision width of an unsigned dw x dw product
   function automatic int unsigned prod_w(input int unsigned dw);
      return 2 * dw;
   endfunction

endpackage

// File: rtl/mac_mult_reg.sv
// One-cycle registered unsigned multiplier; the valid bit travels alongside the product.
module mac_mult_reg #(
   parameter int unsigned DATA_W = mac_pkg::DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   input  logic                  v_in,
   output logic [2*DATA_W-1:0]   prod,
   output logic                  v_out
);

   logic [2*DATA_W-1:0] r_prod;
   logic                r_v;

   // Product only updates on a valid pair so the register is quiet during gaps
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod <= '0;
         r_v    <= 1'b0;
      end else begin
         r_v <= v_in;
         if (v_in) begin
            r_prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
         end
      end
   end

   assign prod  = r_prod;
   assign v_out = r_v;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: latches a job length, streams operand pairs through the
// registered multiplier and returns the sum. Define MAC_ACC_SAT_EN for a saturating accumulator.
module mac_seq_ctrl #(
   parameter int unsigned DATA_W  = mac_pkg::DATA_W,
   parameter int unsigned LEN_MAX = mac_pkg::LEN_MAX,
   parameter int unsigned LEN_W   = mac_pkg::LEN_W,
   parameter int unsigned ACC_W   = mac_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow
);

   import mac_pkg::*;

   localparam int unsigned PROD_W = prod_w(DATA_W);
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(LEN_MAX);

   state_t             r_state;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_count;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic               r_busy;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_acc_out;

   logic               w_accept;
   logic [PROD_W-1:0]  w_prod;
   logic               w_pipe_v;
   logic [SUM_W-1:0]   w_sum;
   logic               w_carry;
   logic [ACC_W-1:0]   w_acc_next;
   logic               w_ovf_next;
   logic [LEN_W-1:0]   w_count_inc;
   logic [LEN_W-1:0]   w_len_clamp;

   // in_ready is only ever set while in RUN, so it alone qualifies acceptance
   assign w_accept    = in_valid & r_in_ready;
   assign w_count_inc = r_count + LEN_W'(1);
   assign w_len_clamp = (len > LEN_CAP) ? LEN_CAP : len;

   mac_mult_reg #(
      .DATA_W (DATA_W)
   ) u_mult (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .v_in  (w_accept),
      .prod  (w_prod),
      .v_out (w_pipe_v)
   );

   // Extra top bit of the sum exposes the carry out of the accumulator
   assign w_sum   = SUM_W'(r_acc) + SUM_W'(w_prod);
   assign w_carry = w_pipe_v & w_sum[ACC_W];

   always_comb begin
      w_acc_next = r_acc;
      if (w_pipe_v) begin
`ifdef MAC_ACC_SAT_EN
         w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
         w_acc_next = w_sum[ACC_W-1:0];
`endif
      end
   end

   assign w_ovf_next = r_ovf | w_carry;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_count     <= '0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_acc_out   <= '0;
      end else begin
         r_acc <= w_acc_next;
         r_ovf <= w_ovf_next;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_len   <= w_len_clamp;
                  r_count <= '0;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  if (w_len_clamp == '0) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                     r_acc_out   <= '0;
                  end else begin
                     r_state    <= RUN;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_accept) begin
                  r_count <= w_count_inc;
                  if (w_count_inc == r_len) begin
                     r_state    <= DRAIN;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            // Last product lands in the accumulator this cycle
            DRAIN: begin
               r_state     <= DONE;
               r_out_valid <= 1'b1;
               r_acc_out   <= w_acc_next;
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign acc_out   = r_acc_out;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: expected results queued at stimulus time, checked on handshake.
module tb_mac_seq_ctrl;

   import mac_pkg::*;

   localparam int unsigned ACC16 = 16;
`ifdef MAC_ACC_SAT_EN
   localparam int unsigned EXP16 = 65535;
`else
   localparam int unsigned EXP16 = 64514;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              overflow;

   logic              s_start;
   logic [LEN_W-1:0]  s_len;
   logic              s_busy;
   logic              s_in_valid;
   logic              s_in_ready;
   logic [DATA_W-1:0] s_a;
   logic [DATA_W-1:0] s_b;
   logic              s_out_valid;
   logic              s_out_ready;
   logic [ACC16-1:0]  s_acc_out;
   logic              s_overflow;

   always #5 clk = ~clk;

   mac_seq_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .overflow  (overflow)
   );

   mac_seq_ctrl #(
      .ACC_W (ACC16)
   ) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .start     (s_start),
      .len       (s_len),
      .busy      (s_busy),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .acc_out   (s_acc_out),
      .overflow  (s_overflow)
   );

   typedef struct packed {
      logic [ACC_W-1:0] acc;
      logic             ovf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_hs     = 0;
   int   n_push   = 0;
   int   rdy_cnt  = 0;
   int   hs_mark  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int unsigned acc, input logic ovf);
      exp_t e;
      e.acc = ACC_W'(acc);
      e.ovf = ovf;
      sb_q.push_back(e);
      n_push++;
   endtask

   task automatic start_job(input int n);
      start = 1'b1;
      len   = LEN_W'(n);
      step();
      start = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int budget);
      int k;
      k = 0;
      while (!out_valid && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(out_valid), 32'd1);
   endtask

   // Result monitor: compares every accepted result against the scoreboard head
   always @(negedge clk) begin
      if (in_ready) rdy_cnt++;
      if (!rst && out_valid && out_ready) begin
         n_hs++;
         if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_acc", 32'(acc_out), 32'(mon_e.acc));
            check("sb_ovf", 32'(overflow), 32'(mon_e.ovf));
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      s_start = 1'b0; s_len = '0; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b0;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_acc_out", 32'(acc_out), 32'd0);
      rst = 1'b0;

      // len=4, back-to-back pairs, stray start mid-job must be ignored
      out_ready = 1'b1;
      push_exp(100, 1'b0);
      start_job(4);
      check("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("t1_rdy", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         a = DATA_W'(2*i + 1);
         b = DATA_W'(2*i + 2);
         start = (i == 1);
         len   = '0;
         step();
      end
      start = 1'b0;
      in_valid = 1'b0;
      check("t1_rdy_drop", 32'(in_ready), 32'd0);
      check("t1_ov_t1", 32'(out_valid), 32'd0);
      step();
      check("t1_ov_t2", 32'(out_valid), 32'd1);
      check("t1_acc", 32'(acc_out), 32'd100);
      step();
      check("t1_busy_idle", 32'(busy), 32'd0);
      check("t1_ov_idle", 32'(out_valid), 32'd0);

      // len=16 of (255,255): max non-overflowing sum
      rdy_cnt = 0;
      push_exp(1040400, 1'b0);
      start_job(16);
      in_valid = 1'b1; a = 8'd255; b = 8'd255;
      repeat (16) step();
      in_valid = 1'b0;
      wait_out("t2_out", 4);
      check("t2_acc", 32'(acc_out), 32'd1040400);
      check("t2_ovf", 32'(overflow), 32'd0);
      step();
      check("t2_rdy_cycles", 32'(rdy_cnt), 32'd16);

      // len above LEN_MAX clamps to 16 pairs
      rdy_cnt = 0;
      push_exp(16, 1'b0);
      start_job(20);
      in_valid = 1'b1; a = 8'd1; b = 8'd1;
      repeat (16) step();
      wait_out("t3_out", 4);
      in_valid = 1'b0;
      step();
      check("t3_rdy_cycles", 32'(rdy_cnt), 32'd16);

      // len=0 goes straight to DONE
      rdy_cnt = 0;
      push_exp(0, 1'b0);
      start_job(0);
      check("t4_ov_next", 32'(out_valid), 32'd1);
      check("t4_acc", 32'(acc_out), 32'd0);
      step();
      check("t4_busy_idle", 32'(busy), 32'd0);
      check("t4_no_ready", 32'(rdy_cnt), 32'd0);

      // Gapped input and back-pressured result
      out_ready = 1'b0;
      push_exp(300, 1'b0);
      start_job(3);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         a = 8'd10; b = 8'd10;
         step();
      end
      in_valid = 1'b0;
      wait_out("t5_out", 4);
      for (int i = 0; i < 5; i++) begin
         check("t5_hold_acc", 32'(acc_out), 32'd300);
         check("t5_hold_ov", 32'(out_valid), 32'd1);
         step();
      end
      out_ready = 1'b1;
      step();
      check("t5_ov_idle", 32'(out_valid), 32'd0);
      check("t5_busy_idle", 32'(busy), 32'd0);

      // 16-bit accumulator overflow: wrap or saturate depending on build
      s_start = 1'b1; s_len = LEN_W'(2);
      step();
      s_start = 1'b0;
      s_in_valid = 1'b1; s_a = 8'd255; s_b = 8'd255;
      repeat (2) step();
      s_in_valid = 1'b0;
      for (int k = 0; k < 4 && !s_out_valid; k++) step();
      check("t6_out", 32'(s_out_valid), 32'd1);
      check("t6_acc", 32'(s_acc_out), 32'(EXP16));
      check("t6_ovf", 32'(s_overflow), 32'd1);
      s_out_ready = 1'b1;
      step();
      check("t6_idle", 32'(s_busy), 32'd0);

      // Reset mid-job abandons it; a fresh job still works
      start_job(4);
      in_valid = 1'b1; a = 8'd5; b = 8'd5;
      step();
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      hs_mark = n_hs;
      step();
      rst = 1'b0;
      check("t7_rst_busy", 32'(busy), 32'd0);
      check("t7_rst_rdy", 32'(in_ready), 32'd0);
      check("t7_rst_ov", 32'(out_valid), 32'd0);
      check("t7_rst_acc", 32'(acc_out), 32'd0);
      push_exp(81, 1'b0);
      start_job(1);
      in_valid = 1'b1; a = 8'd9; b = 8'd9;
      step();
      in_valid = 1'b0;
      wait_out("t7_out", 4);
      check("t7_acc", 32'(acc_out), 32'd81);
      step();
      check("t7_one_result", 32'(n_hs - hs_mark), 32'd1);

      repeat (2) step();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("hs_total", 32'(n_hs), 32'(n_push));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
